hex_sample_loader: RTL
======================

# hex_sample_loader

Host-to-FPGA counterpart of the hex sample dump path. It parses ASCII hex sample lines arriving on the UART receive stream and stores them in an on-chip buffer. It acknowledges the load on the UART transmit stream, then plays the buffer cyclically as a paced sample stream for the sigma-delta DAC input mux. It sits between the `uart` instance (rvalid/rready/rdata, tvalid/tready/tdata) and `sigma_delta_dac`.

## Interface

Parameters:
- NUM_SAMPLES, 4096: buffer depth; a load is exactly NUM_SAMPLES lines.
- SAMPLE_WIDTH, 24: stored/output sample width; each line carries SAMPLE_WIDTH/4 hex digits (6 at default).
- PLAY_DIV, 1024: clocks per output sample during playback (≥ 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rvalid  in  1  UART byte available.
- rready  out  1  byte accepted when rvalid & rready.
- rdata  in  8  received byte.
- tvalid  out  1  status byte valid; held until tready.
- tready  in  1  UART transmitter ready.
- tdata  out  8  status byte.
- dac_sample  out  SAMPLE_WIDTH  current playback sample.
- sample_valid  out  1  one-cycle pulse when dac_sample updates.
- playing  out  1  buffer holds a complete load and is being played.

## Operation

- Reset values: rready=0, tvalid=0, tdata=0, dac_sample=0, sample_valid=0, playing=0, state IDLE, write index=0, read index=0, digit count=0.
- IDLE: rready=1. 'L'(0x4C) or 'l'(0x6C) → LOAD, write index and digit count cleared, playing←0. All other bytes are consumed and ignored.
- PLAY: same byte handling as IDLE; 'L'/'l' stops playback immediately (playing←0, no further sample_valid) and enters LOAD.
- LOAD: each accepted byte is handled as follows:
  - 0-9, A-F, a-f: shift register ← {sr[SAMPLE_WIDTH-5:0], nibble}; digit count +1. A digit arriving when count == SAMPLE_WIDTH/4 is an error.
  - 0x0D: ignored.
  - 0x0A with count == SAMPLE_WIDTH/4: buffer[wr_idx] ← sr; count←0; wr_idx+1. If wr_idx was NUM_SAMPLES-1 → RESP with tdata='K' (0x4B).
  - 0x0A with any other count (including 0): error.
  - Any other byte: error.
  - Error → RESP with tdata='E' (0x45), then IDLE. playing stays 0 and dac_sample holds its value.
- RESP: rready=0, tvalid=1 until the cycle tvalid & tready. Then tvalid←0 and the next state is PLAY after 'K' or IDLE after 'E'.
- PLAY entry: playing←1, rd_idx←0, pace counter←0.
- PLAY pacing: the pace counter counts 0..PLAY_DIV-1. On count PLAY_DIV-1: dac_sample←buffer[rd_idx], sample_valid=1, rd_idx+1 wrapping NUM_SAMPLES-1→0, counter←0.
- Buffer is synchronous single-port-per-direction RAM. The read address is prefetched so dac_sample is correct in the sample_valid cycle.
- dac_sample holds between pulses and outside PLAY.
- Reset mid-operation: all state returns to reset values next cycle. Buffer contents are not cleared but are unusable until a new load; a pending tvalid drops.

## Timing

- rready is registered. It is high in IDLE/LOAD/PLAY and low in RESP; it falls the cycle after the final accepted LF or error byte.
- A byte is consumed in the cycle rvalid & rready; one byte per cycle maximum.
- Final LF accepted at cycle N → tvalid=1 at N+1.
- Status accepted at cycle M (tvalid & tready) → playing=1 at M+1; first sample_valid at M+PLAY_DIV; then one pulse every PLAY_DIV cycles.
- Error byte at cycle N → tvalid=1 with 'E' at N+1.

## Configuration

- LOADER_ECHO_EN defined: every byte accepted in LOAD is echoed on tdata/tvalid before the next byte is accepted. rready stays low from acceptance until the echo's tvalid & tready. The 'K'/'E' status follows the echo of the terminating byte.
- LOADER_ECHO_EN undefined: no echo; tvalid is asserted only for 'K'/'E'.

## Test plan

Run with NUM_SAMPLES=4, PLAY_DIV=8, SAMPLE_WIDTH=24, tready tied high unless stated.

- Valid load: "L" then "00000A\n","FFFFFF\r\n","123abc\n","800000\n" → tdata 'K'. sample_valid every 8 cycles with 0x00000A, 0xFFFFFF, 0x123ABC, 0x800000, 0x00000A (wrap).
- Bad digit: "L","12G456\n" → 'E' on 'G'; state IDLE; playing=0; no sample_valid.
- Short and long lines: "L","12345\n" → 'E'; "L","1234567" → 'E' on the 7th digit.
- Status backpressure: tready low for 50 cycles after the last LF → tvalid and 'K' held stable, rready=0; playback starts PLAY_DIV cycles after the handshake.
- Reload during PLAY: 'L' arrives mid-playback → sample_valid stops next cycle, playing=0, dac_sample holds. A new valid load plays the new data from index 0.
- Reset after 2 of 4 lines → all outputs at reset values; a subsequent full load returns 'K'. With LOADER_ECHO_EN, each load byte is echoed in order before 'K'.

Source files
------------

// File: rtl/hex_sample_loader.sv
// Parses ASCII hex sample lines from the UART into a buffer, acknowledges the load with 'K'/'E', then plays the buffer cyclically.
// Optional LOADER_ECHO_EN: echo every byte accepted in LOAD before accepting the next one.
module hex_sample_loader #(
  parameter int unsigned NUM_SAMPLES  = 4096,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned PLAY_DIV     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [7:0]              rdata,
  output logic                    tvalid,
  input  logic                    tready,
  output logic [7:0]              tdata,
  output logic [SAMPLE_WIDTH-1:0] dac_sample,
  output logic                    sample_valid,
  output logic                    playing
);

  localparam int unsigned ND = SAMPLE_WIDTH / 4;
  localparam int unsigned AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int unsigned DW = $clog2(ND + 1);
  localparam int unsigned PW = $clog2(PLAY_DIV);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_SAMPLES - 1);
  localparam logic [DW-1:0] FULL_CNT  = DW'(ND);
  localparam logic [PW-1:0] PACE_LAST = PW'(PLAY_DIV - 1);
  localparam logic [PW-1:0] PACE_PRE  = PW'(PLAY_DIV - 2);

  localparam logic [7:0] CH_UL = 8'h4C;
  localparam logic [7:0] CH_LL = 8'h6C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RESP, S_PLAY, S_ECHO} state_t;

  state_t                  state, state_d;
  logic [SAMPLE_WIDTH-1:0] sr, sr_d;
  logic [DW-1:0]           dcnt, dcnt_d;
  logic [AW-1:0]           wr_idx, wr_idx_d, rd_idx, rd_idx_d;
  logic [PW-1:0]           pace, pace_d;
  logic [7:0]              code, code_d, tdata_d, fin_code;
  logic [SAMPLE_WIDTH-1:0] dac_d, rd_data;
  logic                    sv_d, playing_d, tvalid_d, rready_d, we, fin, accept;
`ifdef LOADER_ECHO_EN
  logic                    pend, pend_d;
`endif

  logic [SAMPLE_WIDTH-1:0] mem [NUM_SAMPLES];

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  assign accept = rvalid & rready;

  always_comb begin
    state_d   = state;
    sr_d      = sr;
    dcnt_d    = dcnt;
    wr_idx_d  = wr_idx;
    rd_idx_d  = rd_idx;
    pace_d    = pace;
    code_d    = code;
    playing_d = playing;
    dac_d     = dac_sample;
    sv_d      = 1'b0;
    tvalid_d  = tvalid;
    tdata_d   = tdata;
    we        = 1'b0;
    fin       = 1'b0;
    fin_code  = CH_E;
`ifdef LOADER_ECHO_EN
    pend_d    = pend;
`endif
    case (state)
      S_IDLE, S_PLAY: begin
        // Output registers load one cycle early so the pulse lands on pace == PLAY_DIV-1;
        // rd_data already holds buffer[rd_idx] thanks to the prefetched read address.
        if (state == S_PLAY) begin
          pace_d = (pace == PACE_LAST) ? '0 : pace + 1'b1;
          if (pace == PACE_PRE) begin
            sv_d     = 1'b1;
            dac_d    = rd_data;
            rd_idx_d = (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
          end
        end
        if (accept && (rdata == CH_UL || rdata == CH_LL)) begin
          state_d   = S_LOAD;
          wr_idx_d  = '0;
          dcnt_d    = '0;
          playing_d = 1'b0;
          sv_d      = 1'b0;
          dac_d     = dac_sample;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (is_hex(rdata)) begin
            if (dcnt == FULL_CNT) fin = 1'b1;
            else begin
              sr_d   = {sr[SAMPLE_WIDTH-5:0], hex_nib(rdata)};
              dcnt_d = dcnt + 1'b1;
            end
          end else if (rdata == CH_CR) begin
          end else if (rdata == CH_LF && dcnt == FULL_CNT) begin
            we       = 1'b1;
            dcnt_d   = '0;
            wr_idx_d = wr_idx + 1'b1;
            if (wr_idx == LAST_IDX) begin
              fin      = 1'b1;
              fin_code = CH_K;
            end
          end else begin
            fin = 1'b1;
          end
`ifdef LOADER_ECHO_EN
          state_d  = S_ECHO;
          tvalid_d = 1'b1;
          tdata_d  = rdata;
          pend_d   = fin;
          code_d   = fin_code;
`else
          if (fin) begin
            state_d  = S_RESP;
            tvalid_d = 1'b1;
            tdata_d  = fin_code;
            code_d   = fin_code;
          end
`endif
        end
      end
      S_RESP: begin
        if (tready) begin
          tvalid_d = 1'b0;
          if (code == CH_K) begin
            state_d   = S_PLAY;
            playing_d = 1'b1;
            rd_idx_d  = '0;
            pace_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef LOADER_ECHO_EN
      S_ECHO: begin
        if (tready) begin
          if (pend) begin
            state_d = S_RESP;
            tdata_d = code;
          end else begin
            state_d  = S_LOAD;
            tvalid_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    rready_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sr           <= '0;
      dcnt         <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      pace         <= '0;
      code         <= '0;
      playing      <= 1'b0;
      dac_sample   <= '0;
      sample_valid <= 1'b0;
      tvalid       <= 1'b0;
      tdata        <= '0;
      rready       <= 1'b0;
`ifdef LOADER_ECHO_EN
      pend         <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      sr           <= sr_d;
      dcnt         <= dcnt_d;
      wr_idx       <= wr_idx_d;
      rd_idx       <= rd_idx_d;
      pace         <= pace_d;
      code         <= code_d;
      playing      <= playing_d;
      dac_sample   <= dac_d;
      sample_valid <= sv_d;
      tvalid       <= tvalid_d;
      tdata        <= tdata_d;
      rready       <= rready_d;
`ifdef LOADER_ECHO_EN
      pend         <= pend_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= sr;
    rd_data <= mem[rd_idx_d];
  end

endmodule
